// File: rtl/graph_meansq_reduce_if.sv
// Stream bundle for the RMSNorm mean-square stage: int8 element input and RSQRT-index output.
// Optional build macro of the consuming block: GRAPH_MEANSQ_EPS_EN (no effect on this bundle).
interface graph_meansq_reduce_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/graph_meansq_reduce.sv
// Sum-of-squares reduction of an int8 (scale 1/32) vector into a rounded, clamped RSQRT table index.
// Optional macro GRAPH_MEANSQ_EPS_EN adds i_cfg_eps, a saturating offset applied to the index.
module graph_meansq_reduce #(
  parameter int MAX_LOG2_LEN = 10,
  parameter int ACC_W        = 15 + MAX_LOG2_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [3:0]            i_cfg_len_log2,
`ifdef GRAPH_MEANSQ_EPS_EN
  input  logic [6:0]            i_cfg_eps,
`endif
  graph_meansq_reduce_if.slave  bus,
  output logic                  o_busy,
  output logic                  o_err_last
);

  localparam int CNT_W = MAX_LOG2_LEN + 1;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_OUTPUT} state_t;

  state_t              r_state;
  logic [3:0]          r_len_log2;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic [7:0]          r_out_data;
  logic                r_err_last;
`ifdef GRAPH_MEANSQ_EPS_EN
  logic [6:0]          r_eps;
`endif

  logic [3:0]          w_len_sat;
  logic signed [15:0]  w_prod;
  logic [14:0]         w_sq;
  logic [CNT_W-1:0]    w_final_cnt;
  logic                w_is_final;
  logic [4:0]          w_shift;
  logic [SUM_W-1:0]    w_half;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_r;
  logic [6:0]          w_r_clamp;
  logic [6:0]          w_index;

  assign w_len_sat = (i_cfg_len_log2 > 4'(MAX_LOG2_LEN)) ? 4'(MAX_LOG2_LEN) : i_cfg_len_log2;

  // Square of an int8 is at most 16384, so the sign bit of the product is always clear.
  assign w_prod = $signed(bus.in_data) * $signed(bus.in_data);
  assign w_sq   = 15'(unsigned'(w_prod));

  assign w_final_cnt = (CNT_W'(1) << r_len_log2) - CNT_W'(1);
  assign w_is_final  = (r_cnt == w_final_cnt);

  // Mean square in /32 scale is acc / 2^(len+5); add half an LSB first for round-half-up.
  assign w_shift   = 5'(r_len_log2) + 5'd5;
  assign w_half    = SUM_W'(1) << (w_shift - 5'd1);
  assign w_sum     = {1'b0, r_acc} + w_half;
  assign w_r       = w_sum >> w_shift;
  assign w_r_clamp = (|w_r[SUM_W-1:7]) ? 7'd127 : w_r[6:0];

`ifdef GRAPH_MEANSQ_EPS_EN
  logic [7:0] w_r_eps;
  assign w_r_eps = {1'b0, w_r_clamp} + {1'b0, r_eps};
  assign w_index = w_r_eps[7] ? 7'd127 : w_r_eps[6:0];
`else
  assign w_index = w_r_clamp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len_log2  <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err_last  <= 1'b0;
`ifdef GRAPH_MEANSQ_EPS_EN
      r_eps       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len_log2 <= w_len_sat;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_err_last <= 1'b0;
`ifdef GRAPH_MEANSQ_EPS_EN
            r_eps      <= i_cfg_eps;
`endif
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            r_acc <= r_acc + ACC_W'(w_sq);
            r_cnt <= r_cnt + CNT_W'(1);
            // in_last is only audited; the configured length alone ends the vector.
            if (bus.in_last != w_is_final) r_err_last <= 1'b1;
            if (w_is_final) r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_out_data  <= {1'b0, w_index};
          r_out_valid <= 1'b1;
          r_state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err_last    = r_err_last;

endmodule

// File: tb/tb_graph_meansq_reduce.sv
// Bench for graph_meansq_reduce: directed vector table, reset corner case, and randomized
// vectors checked against an arithmetic mean-square model.
module tb_graph_meansq_reduce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] cfg_len;
  logic       busy;
  logic       err_last;
`ifdef GRAPH_MEANSQ_EPS_EN
  logic [6:0] cfg_eps;
`endif

  always #5 clk = ~clk;

  graph_meansq_reduce_if bus();

  graph_meansq_reduce dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_cfg_len_log2 (cfg_len),
`ifdef GRAPH_MEANSQ_EPS_EN
    .i_cfg_eps      (cfg_eps),
`endif
    .bus            (bus.slave),
    .o_busy         (busy),
    .o_err_last     (err_last)
  );

  typedef struct {
    int cfg;
    int eps;
    int pat[4];
    int last_mode;   // 0 correct, 1 extra in_last on element 1, 2 missing final in_last
    int gap_pct;
    int hold;
    bit poke;
    int exp_data;
    int exp_err;
  } vec_t;

  vec_t tbl[$];
  int   q_data[$];
  bit   q_last[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_row(input int cfg, input int eps, input int p0, input int p1, input int p2,
                         input int p3, input int mode, input int gap, input int hold, input bit poke,
                         input int exp_d, input int exp_e);
    vec_t v;
    v.cfg = cfg; v.eps = eps;
    v.pat[0] = p0; v.pat[1] = p1; v.pat[2] = p2; v.pat[3] = p3;
    v.last_mode = mode; v.gap_pct = gap; v.hold = hold; v.poke = poke;
    v.exp_data = exp_d; v.exp_err = exp_e;
    tbl.push_back(v);
  endtask

  // Mean square in /32 scale: sum(x^2)/(N*32), rounded half up, plus eps, clamped to 127.
  function automatic void model(input int cfg, input int eps, output int d, output int e);
    longint sum = 0;
    longint r;
    int lsat = (cfg > 10) ? 10 : cfg;
    longint n = longint'(1) << lsat;
    foreach (q_data[i]) sum += longint'(q_data[i]) * longint'(q_data[i]);
    r = (sum + n * 16) / (n * 32);
    r = r + eps;
    d = (r > 127) ? 127 : int'(r);
    e = 0;
    foreach (q_last[i]) if (q_last[i] != (longint'(i) == n - 1)) e = 1;
  endfunction

  // Called at a negedge; starts immediately so back-to-back calls test earliest restart.
  task automatic run_vec(input string tag, input int cfg, input int gap_pct, input int hold,
                         input bit poke, input int exp_data, input int exp_err);
    int waitc;
    int lat;
    bit stuck = 0;
    logic [7:0] got_data;
    logic got_err;
    start = 1'b1;
    cfg_len = 4'(cfg);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_clr_err"}, err_last, 0);
    for (int i = 0; i < q_data.size() && !stuck; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(q_data[i]);
      bus.in_last  = q_last[i];
      if (poke && i == 1) begin
        start = 1'b1;
        cfg_len = 4'd0;
      end
      waitc = 0;
      while (bus.in_ready !== 1'b1 && waitc < 50) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 50) begin
        stuck = 1;
        check({tag, "_in_ready"}, bus.in_ready, 1);
      end
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_data = bus.out_data;
    got_err  = err_last;
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_latency"}, lat, 2);
    check({tag, "_data"}, got_data, exp_data);
    check({tag, "_err"}, got_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      if (poke) start = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_data"}, bus.out_data, exp_data);
      check({tag, "_hold_err"}, err_last, exp_err);
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, bus.out_valid, 0);
    check({tag, "_post_busy"}, busy, 0);
    $display("%s cfg=%0d n=%0d data=%0d err=%0d lat=%0d", tag, cfg, q_data.size(), got_data, got_err, lat);
  endtask

  task automatic build(input int n, input int p0, input int p1, input int p2, input int p3, input int mode);
    q_data.delete();
    q_last.delete();
    for (int i = 0; i < n; i++) begin
      case (i % 4)
        0: q_data.push_back(p0);
        1: q_data.push_back(p1);
        2: q_data.push_back(p2);
        default: q_data.push_back(p3);
      endcase
      case (mode)
        1: q_last.push_back((i == 1) || (i == n - 1));
        2: q_last.push_back(1'b0);
        default: q_last.push_back(i == n - 1);
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_d;
    int exp_e;
    int eps_r;
    int amp;
    bit saw;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_len = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
`ifdef GRAPH_MEANSQ_EPS_EN
    cfg_eps = 7'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_last", err_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    //      cfg eps  pattern            mode gap hold poke exp  err
    add_row(0,  0,   32,  32,  32,  32, 0,   0,  0,   0,   32,  0);
    add_row(2,  0,   16,  16, -16,  16, 0,   0,  0,   0,   8,   0);
    add_row(0,  0,   3,   3,   3,   3,  0,   0,  0,   0,   0,   0);
    add_row(0,  0,   4,   4,   4,   4,  0,   0,  0,   0,   1,   0);
    add_row(2,  0,   64,  64,  64,  64, 0,   0,  0,   0,   127, 0);
    add_row(10, 0,  -128,-128,-128,-128,0,   0,  0,   0,   127, 0);
    add_row(3,  0,   1,   1,   1,   1,  0,   30, 5,   1,   0,   0);
    add_row(2,  0,   16,  16, -16,  16, 1,   0,  2,   1,   8,   1);
    add_row(2,  0,   16,  16, -16,  16, 0,   0,  0,   0,   8,   0);
    add_row(2,  0,   16,  16, -16,  16, 2,   0,  0,   0,   8,   1);
    add_row(15, 0,   1,   1,   1,   1,  0,   0,  0,   0,   0,   0);
`ifdef GRAPH_MEANSQ_EPS_EN
    add_row(3,  3,   1,   1,   1,   1,  0,   0,  0,   0,   3,   0);
    add_row(2,  127, 16,  16, -16,  16, 0,   0,  0,   0,   127, 0);
`endif

    foreach (tbl[k]) begin
      n = 1 << ((tbl[k].cfg > 10) ? 10 : tbl[k].cfg);
      build(n, tbl[k].pat[0], tbl[k].pat[1], tbl[k].pat[2], tbl[k].pat[3], tbl[k].last_mode);
`ifdef GRAPH_MEANSQ_EPS_EN
      cfg_eps = 7'(tbl[k].eps);
`endif
      run_vec($sformatf("tbl%0d", k), tbl[k].cfg, tbl[k].gap_pct, tbl[k].hold, tbl[k].poke,
              tbl[k].exp_data, tbl[k].exp_err);
    end

    // Reset in the middle of a vector that has already flagged an in_last error.
`ifdef GRAPH_MEANSQ_EPS_EN
    cfg_eps = 7'd0;
`endif
    build(1, 32, 32, 32, 32, 0);
    run_vec("pre_rst", 0, 0, 0, 0, 32, 0);
    start = 1'b1;
    cfg_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'd40;
      bus.in_last = (i == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    check("mid_err_set", err_last, 1);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_err_last", err_last, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) saw = 1'b1;
    end
    check("arst_no_output", saw, 0);
    check("arst_idle", busy, 0);

    for (int k = 0; k < 25; k++) begin
      int len;
      len = $urandom_range(0, 5);
      n = 1 << len;
      case ($urandom_range(0, 2))
        0: amp = 8;
        1: amp = 32;
        default: amp = 127;
      endcase
      q_data.delete();
      q_last.delete();
      for (int i = 0; i < n; i++) begin
        q_data.push_back(int'($urandom_range(0, 2 * amp)) - amp);
        q_last.push_back(i == n - 1);
      end
      if ($urandom_range(0, 99) < 20) begin
        int j;
        j = $urandom_range(0, n - 1);
        q_last[j] = ~q_last[j];
      end
      eps_r = 0;
`ifdef GRAPH_MEANSQ_EPS_EN
      eps_r = $urandom_range(0, 15);
      cfg_eps = 7'(eps_r);
`endif
      model(len, eps_r, exp_d, exp_e);
      run_vec($sformatf("rnd%0d", k), len, $urandom_range(0, 40), $urandom_range(0, 3), 0, exp_d, exp_e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
